// File: rtl/h_dmux16_stream.sv
// ============================================================================
//  Module   : h_dmux16_stream
//  Purpose  : 1-to-2 valid/ready stream demultiplexer with a FIFO per channel.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module h_dmux16_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready,
  output logic             full,
  output logic [15:0]      cnt
);
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_OCC_W-1:0] r_occ;
  logic [15:0]        r_cnt;
  logic               w_pop;

  assign valid = (r_occ != '0);
  assign full  = (r_occ == c_OCC_W'(DEPTH));
  assign w_pop = valid & ready;
  assign cnt   = r_cnt;
  // Head is forced to zero while empty so the output is clean straight out of reset.
  assign dout  = valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_cnt    <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        r_cnt    <= r_cnt + 16'd1;
      end
      case ({push, w_pop})
        2'b10:   r_occ <= r_occ + c_OCC_W'(1);
        2'b01:   r_occ <= r_occ - c_OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end
endmodule

module h_dmux16_stream #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [15:0]      a_cnt,
  output logic [15:0]      b_cnt
);
  logic w_full_a;
  logic w_full_b;
  logic w_push_a;
  logic w_push_b;

  // Ready looks only at the selected channel's occupancy, never at a_ready/b_ready.
  assign in_ready = sel ? !w_full_b : !w_full_a;
  assign w_push_a = in_valid & in_ready & ~sel;
  assign w_push_b = in_valid & in_ready &  sel;

  h_dmux16_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push_a),
    .din   (in),
    .dout  (a),
    .valid (a_valid),
    .ready (a_ready),
    .full  (w_full_a),
    .cnt   (a_cnt)
  );

  h_dmux16_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push_b),
    .din   (in),
    .dout  (b),
    .valid (b_valid),
    .ready (b_ready),
    .full  (w_full_b),
    .cnt   (b_cnt)
  );
endmodule

`default_nettype wire

// File: tb/tb_h_dmux16_stream.sv
// ============================================================================
//  Module   : tb_h_dmux16_stream
//  Purpose  : Self-checking bench for the h_dmux16_stream demultiplexer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_h_dmux16_stream;
  localparam int c_WIDTH = 16;
  localparam int c_DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] b;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] a_cnt;
  logic [15:0] b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  h_dmux16_stream #(
    .WIDTH (c_WIDTH),
    .DEPTH (c_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b        (b),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  initial begin
    int   sent_a;
    int   sent_b;
    int   cyc;
    int   acc;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    bit   m_rdy;
    bit   do_push;
    bit   a_pop;
    bit   b_pop;
    bit   f;

    rst_n    = 1'b1;
    in       = '0;
    sel      = 1'b0;
    in_valid = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    // Reset state
    check_eq("rst_a_valid", a_valid, 0);
    check_eq("rst_b_valid", b_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    step();
    step();
    check_eq("rst_a_cnt", a_cnt, 0);
    check_eq("rst_b_cnt", b_cnt, 0);
    check_eq("rst_a", a, 0);
    check_eq("rst_b", b, 0);
    rst_n = 1'b1;

    // Routing
    a_ready = 1'b1;
    b_ready = 1'b1;
    in = 16'h1234; sel = 1'b0; in_valid = 1'b1;
    #1 check_eq("rt_in_ready", in_ready, 1);
    step();
    check_eq("rt_a_valid1", a_valid, 1);
    check_eq("rt_a1", a, 16'h1234);
    in = 16'hABCD; sel = 1'b1;
    step();
    check_eq("rt_b_valid", b_valid, 1);
    check_eq("rt_b", b, 16'hABCD);
    check_eq("rt_a_empty", a_valid, 0);
    in = 16'h0001; sel = 1'b0;
    step();
    check_eq("rt_a2", a, 16'h0001);
    in_valid = 1'b0;
    step();
    check_eq("rt_a_cnt", a_cnt, 2);
    check_eq("rt_b_cnt", b_cnt, 1);

    // Backpressure and full
    a_ready = 1'b0;
    in = 16'h0011; sel = 1'b0; in_valid = 1'b1;
    step();
    in = 16'h0022;
    step();
    in = 16'h0033;
    #1 check_eq("bp_full_rdy", in_ready, 0);
    check_eq("bp_head", a, 16'h0011);
    a_ready = 1'b1;
    #1 check_eq("bp_full_pop_rdy", in_ready, 0);
    step();
    check_eq("bp_after_pop_rdy", in_ready, 1);
    check_eq("bp_head2", a, 16'h0022);
    a_ready = 1'b0;
    step();
    in_valid = 1'b0;

    // Isolation: a holds 0x22,0x33 and is stalled
    sel = 1'b0;
    #1 check_eq("iso_a_full", in_ready, 0);
    in = 16'h5555; sel = 1'b1; in_valid = 1'b1; b_ready = 1'b0;
    #1 check_eq("iso_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq("iso_b_valid", b_valid, 1);
    check_eq("iso_b", b, 16'h5555);
    check_eq("iso_a_head", a, 16'h0022);
    check_eq("iso_a_cnt", a_cnt, 3);

    // Simultaneous push and pop on b
    b_ready = 1'b1;
    in = 16'h6666; sel = 1'b1; in_valid = 1'b1;
    #1 check_eq("pp_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq("pp_b_valid", b_valid, 1);
    check_eq("pp_b", b, 16'h6666);
    check_eq("pp_b_cnt", b_cnt, 2);
    step();
    check_eq("pp_b_empty", b_valid, 0);
    check_eq("pp_b_cnt2", b_cnt, 3);
    step();
    check_eq("pp_b_idle_cnt", b_cnt, 3);

    // Drain a
    a_ready = 1'b1;
    step();
    check_eq("dr_a_head", a, 16'h0033);
    step();
    check_eq("dr_a_valid", a_valid, 0);
    check_eq("dr_a_cnt", a_cnt, 5);

    // Reset mid-run with two words buffered in a
    a_ready = 1'b0;
    in = 16'h0077; sel = 1'b0; in_valid = 1'b1;
    step();
    in = 16'h0088;
    step();
    in_valid = 1'b0;
    check_eq("mr_a_valid_pre", a_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_a_valid", a_valid, 0);
    check_eq("mr_a_cnt", a_cnt, 0);
    check_eq("mr_in_ready", in_ready, 1);
    check_eq("mr_a", a, 0);
    step();
    rst_n = 1'b1;
    a_ready = 1'b1;
    step();
    check_eq("mr_no_pop_valid", a_valid, 0);
    check_eq("mr_no_pop_cnt", a_cnt, 0);

    // Random traffic against a scoreboard
    sent_a = 0; sent_b = 0; cyc = 0;
    exp_a = '0; exp_b = '0;
    in_valid = 1'b0;
    while ((sent_a < 100 || sent_b < 100 || qa.size() != 0 || qb.size() != 0 || in_valid)
           && cyc < 5000) begin
      if (!in_valid && (sent_a < 100 || sent_b < 100)) begin
        if (sent_a >= 100)      sel = 1'b1;
        else if (sent_b >= 100) sel = 1'b0;
        else                    sel = 1'($urandom_range(0, 1));
        in       = 16'($urandom);
        in_valid = 1'b1;
      end
      a_ready = 1'($urandom_range(0, 1));
      b_ready = 1'($urandom_range(0, 1));
      #1;
      check_eq("rnd_a_valid", a_valid, 32'(qa.size() != 0));
      if (qa.size() != 0) check_eq("rnd_a", a, qa[0]);
      check_eq("rnd_b_valid", b_valid, 32'(qb.size() != 0));
      if (qb.size() != 0) check_eq("rnd_b", b, qb[0]);
      m_rdy = sel ? (qb.size() < c_DEPTH) : (qa.size() < c_DEPTH);
      if (in_valid) check_eq("rnd_in_ready", in_ready, 32'(m_rdy));
      do_push = in_valid && m_rdy;
      a_pop   = (qa.size() != 0) && a_ready;
      b_pop   = (qb.size() != 0) && b_ready;
      step();
      if (a_pop) begin void'(qa.pop_front()); exp_a++; end
      if (b_pop) begin void'(qb.pop_front()); exp_b++; end
      if (do_push) begin
        if (sel) begin qb.push_back(in); sent_b++; end
        else     begin qa.push_back(in); sent_a++; end
        in_valid = 1'b0;
      end
      cyc++;
    end
    check_eq("rnd_done", 32'(cyc < 5000), 1);
    check_eq("rnd_a_cnt", a_cnt, exp_a);
    check_eq("rnd_b_cnt", b_cnt, exp_b);
    check_eq("rnd_a_total", 32'(exp_a), 100);

    // Counter wrap: 65537 words on a
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    a_ready = 1'b1; b_ready = 1'b0; sel = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 65537 && cyc < 70000) begin
      in = 16'(acc);
      in_valid = 1'b1;
      #1 f = in_ready;
      step();
      if (f) acc++;
      cyc++;
    end
    in_valid = 1'b0;
    repeat (4) step();
    check_eq("wr_accepted", acc, 65537);
    check_eq("wr_a_cnt", a_cnt, 16'h0001);
    check_eq("wr_a_valid", a_valid, 0);
    check_eq("wr_b_cnt", b_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/h_dmux16_stream.md
Name: h_dmux16_stream

Overview:
- 1-to-2 stream demultiplexer. It is the routing inverse of the 16-bit 2:1 word selector: one input word stream is steered to output channel a or channel b by a per-word select bit.
- Each channel has its own small FIFO, so a stalled channel never blocks words bound for the other channel once they are buffered.
- Sits between the CPU-side data path and two downstream consumers, e.g. the memory-write path and the I/O (screen/keyboard) path of the Hack computer.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 2, entries per channel FIFO; power of two, 2 to 16.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  input data word.
- sel  input  1  destination of the current word: 0 routes to channel a, 1 routes to channel b.
- in_valid  input  1  in and sel are valid this cycle.
- in_ready  output  1  block accepts the word this cycle.
- a  output  WIDTH  channel a data (FIFO head).
- a_valid  output  1  channel a holds data.
- a_ready  input  1  consumer a takes the word.
- b  output  WIDTH  channel b data (FIFO head).
- b_valid  output  1  channel b holds data.
- b_ready  input  1  consumer b takes the word.
- a_cnt  output  16  words delivered on channel a; wraps modulo 2^16.
- b_cnt  output  16  words delivered on channel b; wraps modulo 2^16.

Behaviour:
- Reset, asserted asynchronously, all take effect immediately:
  - both FIFOs empty, all pointers and occupancy = 0;
  - a_valid = b_valid = 0;
  - a_cnt = b_cnt = 0;
  - a = b = 0;
  - in_ready = 1.
  - Reset mid-transfer discards all buffered words. No handshake completes in a cycle where rst_n = 0.
- Handshake: valid/ready. A transfer occurs on a rising edge where valid & ready = 1.
  - Valid, once asserted by the producer, is held with stable data until accepted.
- in_ready = !full(sel).
  - It depends only on sel and the occupancy of the selected channel, never on a_ready or b_ready. This means there is no combinational path from the output-side ready signals to in_ready.
- Accept: on in_valid & in_ready, the word is pushed into the selected channel's FIFO.
  - sel is sampled only at the accept edge.
  - The other channel is unaffected.
- Latency:
  - An accepted word into an empty FIFO appears with x_valid = 1 in the next cycle.
  - Empty-FIFO bypass is not permitted, so minimum latency is 1 cycle.
- Output: x_valid = (occupancy_x != 0). The x output is the FIFO head.
  - Pop on x_valid & x_ready.
  - x_cnt increments by 1 on each pop and wraps from 0xFFFF to 0x0000.
- Ordering: words on each channel leave in acceptance order. No ordering is guaranteed between channels.
- Simultaneous push and pop on the same channel: occupancy is unchanged and both operations take effect.
  - When that channel is full, in_ready = 0 regardless of the same-cycle pop. The push retries next cycle.
- Empty channel with x_ready = 1 and no data: nothing happens; x_cnt is unchanged.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy is a separate counter 0..DEPTH, so full and empty are distinguishable.
- Independence: channel a full with in_valid = 1 and sel = 1 is still accepted if channel b is not full.
- Channel a and channel b handshakes may complete in the same cycle as an input accept.

Test Plan:
- Reset:
  - Stimulus: hold rst_n = 0 mid-run with 2 words buffered in a.
  - Required: a_valid = 0 immediately, not at the next edge; a_cnt = 0; in_ready = 1. After release, a_ready = 1 yields no pop.
- Routing:
  - Stimulus: send 0x1234 (sel = 0), 0xABCD (sel = 1), 0x0001 (sel = 0), with a_ready = b_ready = 1.
  - Required: a shows 0x1234 then 0x0001; b shows 0xABCD; each appears 1 cycle after accept; a_cnt = 2, b_cnt = 1.
- Backpressure and full:
  - Stimulus: a_ready = 0; offer 0x0011, 0x0022, 0x0033 with sel = 0.
  - Required: first two accepted; in_ready = 0 on the third. Raising a_ready pops 0x0011 that cycle; 0x0033 is accepted on the following cycle, not the same one.
- Isolation:
  - Stimulus: channel a full and stalled; offer 0x5555 with sel = 1.
  - Required: in_ready = 1, accepted, b = 0x5555 next cycle; channel a contents unchanged.
- Simultaneous push/pop:
  - Stimulus: channel b holding 1 word, push and pop on b in the same cycle.
  - Required: occupancy stays 1; b_cnt +1; order preserved over 100 random words per channel, compared against a scoreboard.
- Counter wrap:
  - Stimulus: deliver 65537 words on a.
  - Required: a_cnt = 0x0001.
